// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
//
// Purpose:
//   Sequences an external combinational ALU from operand entry to a captured
//   result. An execute pulse latches operand A (entered value, or the previous
//   result in accumulate mode), operand B and the op code. These are held
//   stable on the ALU inputs for LAT settle cycles. The result and zero flag
//   are then captured, together with the optional signed overflow flag, and
//   the completed-operation counter is advanced. A registered 32-bit display
//   word is selected for the 7-segment path.
//
// Optional feature macro:
//   ALU_OVF_DETECT_EN - when defined, ovf_q captures the signed overflow of
//                       add/sub. When undefined, ovf_q stays 0.
//
// Parameters:
//   LAT    ALU settle cycles after operand latch (0..15)
//   CNT_W  width of the completed-operation counter
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Ai, Bi     in   operands from the hex entry block
//   ALU_Ctrl   in   op code (000 and, 001 or, 010 add, 011 xor, 100 nor,
//                   101 srl, 110 sub, 111 slt)
//   exec       in   one-cycle execute pulse
//   clear      in   one-cycle pulse: clears result, flags, valid and counter
//   acc_mode   in   1 = use last result as operand A
//   disp_sel   in   display source select
//   alu_res    in   ALU result (combinational)
//   alu_zero   in   ALU zero flag
//   alu_A/B    out  latched operands to the ALU
//   alu_op     out  latched op code to the ALU
//   res_q      out  captured result
//   zero_q     out  captured zero flag
//   ovf_q      out  captured signed overflow
//   valid      out  res_q holds a result since reset/clear
//   busy       out  operation in flight
//   done       out  one-cycle pulse on capture
//   op_cnt     out  completed operations, wraps
//   disp_data  out  registered display word
// -----------------------------------------------------------------------------
module alu_exec_ctrl #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Ai,
    input  logic [31:0]       Bi,
    input  logic [2:0]        ALU_Ctrl,
    input  logic              exec,
    input  logic              clear,
    input  logic              acc_mode,
    input  logic [1:0]        disp_sel,
    input  logic [31:0]       alu_res,
    input  logic              alu_zero,
    output logic [31:0]       alu_A,
    output logic [31:0]       alu_B,
    output logic [2:0]        alu_op,
    output logic [31:0]       res_q,
    output logic              zero_q,
    output logic              ovf_q,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  op_cnt,
    output logic [31:0]       disp_data
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic [31:0]        alu_a_r;
    logic [31:0]        alu_b_r;
    logic [2:0]         alu_op_r;
    logic [31:0]        res_q_r;
    logic               zero_q_r;
    logic               ovf_q_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   op_cnt_r;
    logic [31:0]        disp_data_r;

    logic               ovf_s;
    logic [23:0]        cnt_ext_s;
    logic [31:0]        status_word_s;

`ifdef ALU_OVF_DETECT_EN
    // Signed overflow of the latched operation; only add and sub can overflow.
    function automatic logic ovf_calc(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] r
    );
        logic ovf;
        case (op)
            3'b010:  ovf = (a[31] == b[31]) && (r[31] != a[31]);
            3'b110:  ovf = (a[31] != b[31]) && (r[31] != a[31]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

    // Overflow is judged on the held ALU inputs, not the live entry operands.
    assign ovf_s = ovf_calc(alu_op_r, alu_a_r, alu_b_r, alu_res);
`else
    // Overflow detection absent: flag never sets.
    assign ovf_s = 1'b0;
`endif

    // Counter zero-extended (or truncated for very wide counters) into the
    // 24-bit field of the status word.
    assign cnt_ext_s     = 24'(op_cnt_r);
    assign status_word_s = {cnt_ext_s, 5'b00000, ovf_q_r, zero_q_r, valid_r};

    // Execute sequencer: operand latch, settle countdown and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            alu_a_r  <= 32'h0000_0000;
            alu_b_r  <= 32'h0000_0000;
            alu_op_r <= 3'b000;
            res_q_r  <= 32'h0000_0000;
            zero_q_r <= 1'b0;
            ovf_q_r  <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            op_cnt_r <= '0;
        end else begin
            // done is a single-cycle pulse unless capture re-asserts it below.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // clear has priority; a coincident exec is dropped.
                    if (clear) begin
                        res_q_r  <= 32'h0000_0000;
                        zero_q_r <= 1'b0;
                        ovf_q_r  <= 1'b0;
                        valid_r  <= 1'b0;
                        op_cnt_r <= '0;
                    end else if (exec) begin
                        // Accumulate only once a real result exists.
                        alu_a_r  <= (acc_mode && valid_r) ? res_q_r : Ai;
                        alu_b_r  <= Bi;
                        alu_op_r <= ALU_Ctrl;
                        cnt_r    <= LAT_C;
                        busy_r   <= 1'b1;
                        state_r  <= ST_WAIT;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // exec and clear are ignored while an operation settles.
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        res_q_r  <= alu_res;
                        zero_q_r <= alu_zero;
                        ovf_q_r  <= ovf_s;
                        valid_r  <= 1'b1;
                        op_cnt_r <= op_cnt_r + CNT_W'(1);
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a quiet idle.
                    busy_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Display word: one-cycle registered copy of the selected source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data_r <= 32'h0000_0000;
        end else begin
            case (disp_sel)
                2'b00:   disp_data_r <= alu_a_r;
                2'b01:   disp_data_r <= alu_b_r;
                2'b10:   disp_data_r <= res_q_r;
                2'b11:   disp_data_r <= status_word_s;
                default: disp_data_r <= 32'h0000_0000;
            endcase
        end
    end

    assign alu_A     = alu_a_r;
    assign alu_B     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign res_q     = res_q_r;
    assign zero_q    = zero_q_r;
    assign ovf_q     = ovf_q_r;
    assign valid     = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign op_cnt    = op_cnt_r;
    assign disp_data = disp_data_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//
// Table-driven bench for alu_exec_ctrl. A small behavioural ALU closes the
// loop from alu_A/alu_B/alu_op back to alu_res/alu_zero. Each table record
// carries hand-computed expected values. Hand-written sequences cover exec
// while busy, clear priority, clear in WAIT, back-to-back exec, reset
// mid-operation and counter wrap.
// Optional feature macro: ALU_OVF_DETECT_EN (switches the ovf expectations).
// -----------------------------------------------------------------------------
module tb_alu_exec_ctrl;

    localparam int unsigned LAT = 2;

`ifdef ALU_OVF_DETECT_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Ai, Bi;
    logic [2:0]  ALU_Ctrl;
    logic        exec, clear, acc_mode;
    logic [1:0]  disp_sel;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic [31:0] alu_A, alu_B;
    logic [2:0]  alu_op;
    logic [31:0] res_q;
    logic        zero_q, ovf_q, valid, busy, done;
    logic [7:0]  op_cnt;
    logic [31:0] disp_data;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_cnt;

    alu_exec_ctrl #(.LAT(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .Ai(Ai), .Bi(Bi), .ALU_Ctrl(ALU_Ctrl),
        .exec(exec), .clear(clear), .acc_mode(acc_mode), .disp_sel(disp_sel),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_A(alu_A), .alu_B(alu_B),
        .alu_op(alu_op), .res_q(res_q), .zero_q(zero_q), .ovf_q(ovf_q),
        .valid(valid), .busy(busy), .done(done), .op_cnt(op_cnt),
        .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    // Behavioural framework ALU.
    always_comb begin
        case (alu_op)
            3'b000:  alu_res = alu_A & alu_B;
            3'b001:  alu_res = alu_A | alu_B;
            3'b010:  alu_res = alu_A + alu_B;
            3'b011:  alu_res = alu_A ^ alu_B;
            3'b100:  alu_res = ~(alu_A | alu_B);
            3'b101:  alu_res = alu_A >> alu_B[4:0];
            3'b110:  alu_res = alu_A - alu_B;
            3'b111:  alu_res = ($signed(alu_A) < $signed(alu_B)) ? 32'd1 : 32'd0;
            default: alu_res = 32'd0;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        acc;
        logic [31:0] exp_a;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ovf;   // value when overflow detection is built in
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until done is seen; n = cycles taken (0 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    // Issue one exec pulse and wait for its capture; returns observed latency.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic acc, output int lat);
        Ai = a; Bi = b; ALU_Ctrl = op; acc_mode = acc; exec = 1'b1;
        step();
        exec = 1'b0; acc_mode = 1'b0;
        chk("busy_after_exec", {31'd0, busy}, 32'd1);
        wait_done(lat);
    endtask

    initial begin
        int   lat;
        int   n;
        int   pulses;
        logic seen_done;

        rst_n = 1'b0; Ai = 32'd0; Bi = 32'd0; ALU_Ctrl = 3'b000;
        exec = 1'b0; clear = 1'b0; acc_mode = 1'b0; disp_sel = 2'b00;
        exp_cnt = 8'd0;

        //             a             b             op      acc   exp_a         exp_res       zero  ovf
        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 3'b010, 1'b0, 32'h0000_0005, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{32'h1111_1111, 32'h0000_0008, 3'b110, 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b0, 32'hF0F0_F0F0, 32'hF000_F000, 1'b0, 1'b0};
        vecs[3]  = '{32'h1234_0000, 32'h0000_5678, 3'b001, 1'b0, 32'h1234_0000, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4]  = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'b011, 1'b0, 32'hFFFF_0000, 32'hF0F0_0F0F, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_FFFF, 32'h00FF_0000, 3'b100, 1'b0, 32'h0000_FFFF, 32'hFF00_0000, 1'b0, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0004, 3'b101, 1'b0, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
        vecs[9]  = '{32'h8000_0000, 32'h0000_0001, 3'b110, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
        vecs[11] = '{32'h0000_0099, 32'h0000_0005, 3'b010, 1'b1, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0};

        // Reset state.
        #12;
        chk("rst_res_q",  res_q, 32'd0);
        chk("rst_alu_A",  alu_A, 32'd0);
        chk("rst_flags",  {26'd0, zero_q, ovf_q, valid, busy, done, 1'b0}, 32'd0);
        chk("rst_op_cnt", {24'd0, op_cnt}, 32'd0);
        chk("rst_disp",   disp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table of operations.
        for (int i = 0; i < 12; i++) begin
            logic ovf_e;
            ovf_e = vecs[i].exp_ovf & OVF_ON;
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].acc, lat);
            exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("v%0d_latency", i), lat, LAT + 1);
            chk($sformatf("v%0d_res_q", i), res_q, vecs[i].exp_res);
            chk($sformatf("v%0d_alu_A", i), alu_A, vecs[i].exp_a);
            chk($sformatf("v%0d_alu_B", i), alu_B, vecs[i].b);
            chk($sformatf("v%0d_alu_op", i), {29'd0, alu_op}, {29'd0, vecs[i].op});
            chk($sformatf("v%0d_flags", i), {28'd0, zero_q, ovf_q, valid, busy},
                {28'd0, vecs[i].exp_zero, ovf_e, 1'b1, 1'b0});
            chk($sformatf("v%0d_op_cnt", i), {24'd0, op_cnt}, {24'd0, exp_cnt});
            disp_sel = 2'b00; step();
            chk($sformatf("v%0d_disp_A", i), disp_data, vecs[i].exp_a);
            disp_sel = 2'b01; step();
            chk($sformatf("v%0d_disp_B", i), disp_data, vecs[i].b);
            disp_sel = 2'b10; step();
            chk($sformatf("v%0d_disp_res", i), disp_data, vecs[i].exp_res);
            disp_sel = 2'b11; step();
            chk($sformatf("v%0d_disp_stat", i), disp_data,
                {16'd0, exp_cnt, 5'd0, ovf_e, vecs[i].exp_zero, 1'b1});
        end

        // exec while busy is ignored and not queued.
        Ai = 32'h10; Bi = 32'h20; ALU_Ctrl = 3'b010; exec = 1'b1;
        step();
        Ai = 32'h99; Bi = 32'h1; ALU_Ctrl = 3'b011;
        step();
        exec = 1'b0;
        chk("busy_exec_alu_A", alu_A, 32'h10);
        chk("busy_exec_alu_op", {29'd0, alu_op}, 32'd2);
        wait_done(n);
        exp_cnt = exp_cnt + 8'd1;
        chk("busy_exec_latency", n, LAT);
        chk("busy_exec_res", res_q, 32'h30);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_done = seen_done | done | busy;
        end
        chk("busy_exec_not_queued", {31'd0, seen_done}, 32'd0);
        chk("busy_exec_op_cnt", {24'd0, op_cnt}, {24'd0, exp_cnt});

        // clear and exec together in IDLE: clear wins.
        clear = 1'b1; exec = 1'b1; Ai = 32'h1; Bi = 32'h1;
        step();
        clear = 1'b0; exec = 1'b0;
        exp_cnt = 8'd0;
        chk("clr_exec_state", {29'd0, busy, valid, zero_q}, 32'd0);
        chk("clr_exec_res", res_q, 32'd0);
        chk("clr_exec_op_cnt", {24'd0, op_cnt}, 32'd0);
        step();
        chk("clr_exec_no_start", {31'd0, busy}, 32'd0);

        // acc_mode with valid=0 uses Ai.
        run_op(32'h7, 32'h1, 3'b010, 1'b1, lat);
        exp_cnt = exp_cnt + 8'd1;
        chk("acc_novalid_alu_A", alu_A, 32'h7);
        chk("acc_novalid_res", res_q, 32'h8);

        // clear during WAIT is ignored.
        Ai = 32'h3; Bi = 32'h4; ALU_Ctrl = 3'b010; exec = 1'b1;
        step();
        exec = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        wait_done(n);
        exp_cnt = exp_cnt + 8'd1;
        chk("clr_wait_res", res_q, 32'h7);
        chk("clr_wait_valid", {31'd0, valid}, 32'd1);
        chk("clr_wait_op_cnt", {24'd0, op_cnt}, {24'd0, exp_cnt});

        // Back-to-back: exec while done is high is accepted.
        chk("b2b_done_high", {31'd0, done}, 32'd1);
        run_op(32'h2, 32'h2, 3'b010, 1'b0, lat);
        exp_cnt = exp_cnt + 8'd1;
        chk("b2b_latency", lat, LAT + 1);
        chk("b2b_res", res_q, 32'h4);

        // Reset asserted mid-WAIT aborts the operation.
        Ai = 32'h55; Bi = 32'h11; ALU_Ctrl = 3'b010; exec = 1'b1;
        step();
        exec = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_wait_regs", alu_A | alu_B | res_q | disp_data, 32'd0);
        chk("rst_wait_flags", {24'd0, op_cnt} | {27'd0, busy, done, valid, zero_q, ovf_q}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen_done = seen_done | done;
        end
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen_done = seen_done | done | busy;
        end
        chk("rst_wait_no_done", {31'd0, seen_done}, 32'd0);
        run_op(32'h6, 32'h7, 3'b011, 1'b0, lat);
        exp_cnt = exp_cnt + 8'd1;
        chk("post_rst_latency", lat, LAT + 1);
        chk("post_rst_res", res_q, 32'h1);
        chk("post_rst_op_cnt", {24'd0, op_cnt}, 32'd1);

        // Counter wrap at all-ones.
        while (exp_cnt != 8'hFF) begin
            run_op(32'h1, 32'h1, 3'b000, 1'b0, lat);
            exp_cnt = exp_cnt + 8'd1;
        end
        chk("wrap_cnt_255", {24'd0, op_cnt}, 32'd255);
        Ai = 32'h1; Bi = 32'h2; ALU_Ctrl = 3'b001; exec = 1'b1;
        step();
        exec = 1'b0;
        pulses = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            step();
            if (done) pulses++;
        end
        chk("wrap_done_pulses", pulses, 1);
        chk("wrap_cnt_0", {24'd0, op_cnt}, 32'd0);
        chk("wrap_res", res_q, 32'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
